// File: rtl/acc_out_serializer.sv
// Captures whole accelerator result vectors into a small vector FIFO and
// streams them out as fixed-width beats over valid/ready, flagging dropped vectors.
module acc_out_serializer #(
  parameter int outputElements = 32,
  parameter int outputBits     = 4,
  parameter int beatElements   = 8,
  parameter int fifoDepth      = 2,
  localparam int numBeats      = outputElements / beatElements,
  localparam int beatIdxBits   = (numBeats > 1) ? $clog2(numBeats) : 1,
  localparam int cntBits       = $clog2(fifoDepth + 1)
) (
  input  logic                                        clk,
  input  logic                                        nrst,
  input  logic                                        valid_i,
  input  logic [outputElements-1:0][outputBits-1:0]   mac_data_i,
  input  logic                                        clear_i,
  output logic                                        out_valid_o,
  input  logic                                        out_ready_i,
  output logic [beatElements-1:0][outputBits-1:0]     out_data_o,
  output logic                                        out_last_o,
  output logic [beatIdxBits-1:0]                      out_beat_idx_o,
  output logic [cntBits-1:0]                          fifo_count_o,
  output logic                                        overflow_o
);

  localparam int vecW    = outputElements * outputBits;
  localparam int beatW   = beatElements * outputBits;
  localparam int ptrBits = $clog2(fifoDepth);

  if (outputElements % beatElements != 0) begin : g_bad_beat
    $fatal(1, "acc_out_serializer: outputElements must be a multiple of beatElements");
  end
  if (fifoDepth < 2 || (fifoDepth & (fifoDepth - 1)) != 0) begin : g_bad_depth
    $fatal(1, "acc_out_serializer: fifoDepth must be a power of two >= 2");
  end

  typedef enum logic {S_EMPTY, S_STREAM} state_t;

  state_t                 state_q, state_d;
  logic [ptrBits-1:0]     wptr_q, rptr_q;
  logic [cntBits-1:0]     count_q, count_d;
  logic [beatIdxBits-1:0] beat_q, beat_d;
  logic                   ovf_q, ovf_d;
  logic                   hs, last_beat, pop, full, wr, drop;
  logic [vecW-1:0]        mem [fifoDepth];
  logic [vecW-1:0]        head;
  int                     base;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
      if (wr)  wptr_q <= wptr_q + ptrBits'(1);
      if (pop) rptr_q <= rptr_q + ptrBits'(1);
    end
  end

  // Vector storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= mac_data_i;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    beat_d      = beat_q;
    ovf_d       = ovf_q;
    out_valid_o = (state_q == S_STREAM);
    last_beat   = (beat_q == beatIdxBits'(numBeats - 1));
    hs          = out_valid_o && out_ready_i;
    pop         = hs && last_beat;
    full        = (count_q == cntBits'(fifoDepth));
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    wr          = valid_i && (!full || pop);
    drop        = valid_i && full && !pop;
    out_last_o  = out_valid_o && last_beat;

    if (hs) beat_d = last_beat ? '0 : beat_q + beatIdxBits'(1);

    case ({wr, pop})
      2'b10:   count_d = count_q + cntBits'(1);
      2'b01:   count_d = count_q - cntBits'(1);
      default: count_d = count_q;
    endcase

    if (drop)         ovf_d = 1'b1;
    else if (clear_i) ovf_d = 1'b0;

    state_d = (count_d != '0) ? S_STREAM : S_EMPTY;
  end

  always_comb begin
    head       = mem[rptr_q];
    base       = int'(beat_q) * beatW;
    out_data_o = head[base +: beatW];
  end

  assign out_beat_idx_o = beat_q;
  assign fifo_count_o   = count_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_acc_out_serializer.sv
// Bench for acc_out_serializer: hand-derived vector table, reset corner cases,
// and a randomized run against a queue-based model of the vector FIFO.
module tb_acc_out_serializer;

  localparam int OE = 32;
  localparam int OB = 4;
  localparam int BE = 8;
  localparam int NB = OE / BE;
  localparam int DEPTH = 2;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic                  valid_i;
  logic [OE-1:0][OB-1:0] mac_data;
  logic                  clear_i;
  logic                  out_valid;
  logic                  out_ready;
  logic [BE-1:0][OB-1:0] out_data;
  logic                  out_last;
  logic [1:0]            out_beat_idx;
  logic [1:0]            fifo_count;
  logic                  overflow;

  int checks = 0;
  int errors = 0;

  acc_out_serializer #(
    .outputElements(OE), .outputBits(OB), .beatElements(BE), .fifoDepth(DEPTH)
  ) dut (
    .clk(clk), .nrst(nrst), .valid_i(valid_i), .mac_data_i(mac_data),
    .clear_i(clear_i), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last), .out_beat_idx_o(out_beat_idx),
    .fifo_count_o(fifo_count), .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; int pat; logic rdy; logic clr;
    logic e_valid; int e_beat; logic e_last; int e_cnt; logic e_ovf; int e_pat;
  } row_t;

  row_t rows[$];

  logic [OE*OB-1:0] mq[$];
  int               m_beat;
  logic             m_ovf;

  function automatic logic [OE*OB-1:0] pat_vec(input int p);
    logic [OE*OB-1:0] v;
    for (int k = 0; k < OE; k++) v[k*OB +: OB] = 4'((k + p) % 16);
    return v;
  endfunction

  function automatic logic [31:0] beat_of(input logic [OE*OB-1:0] v, input int b);
    return v[b*BE*OB +: BE*OB];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input int pat, input logic rdy, input logic clr,
                     input logic ev, input int eb, input logic el, input int ec,
                     input logic eo, input int ep);
    row_t r;
    r.v = v; r.pat = pat; r.rdy = rdy; r.clr = clr;
    r.e_valid = ev; r.e_beat = eb; r.e_last = el; r.e_cnt = ec; r.e_ovf = eo; r.e_pat = ep;
    rows.push_back(r);
  endtask

  // Ready-high rows walking beats first..NB-1 of the head vector.
  task automatic add_beats(input int pat, input int cnt, input int first);
    for (int b = first; b < NB; b++) add(0, 0, 1, 0, 1, b, b == NB - 1, cnt, 0, pat);
  endtask

  task automatic drive(input logic v, input logic [OE*OB-1:0] d, input logic rdy, input logic clr);
    valid_i = v; mac_data = d; out_ready = rdy; clear_i = clr;
  endtask

  task automatic model_edge(input logic v, input logic [OE*OB-1:0] d, input logic rdy, input logic clr);
    int   sz;
    logic popping, dropped;
    sz = mq.size(); popping = 0; dropped = 0;
    if (sz > 0 && rdy) begin
      if (m_beat == NB - 1) begin
        popping = 1; void'(mq.pop_front()); m_beat = 0;
      end else m_beat++;
    end
    if (v) begin
      if (sz < DEPTH || popping) mq.push_back(d);
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic check_model(input string tag);
    logic ev;
    ev = mq.size() > 0;
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".count"}, 32'(fifo_count), 32'(mq.size()));
    chk({tag, ".beat"}, 32'(out_beat_idx), ev ? 32'(m_beat) : 32'd0);
    chk({tag, ".last"}, 32'(out_last), 32'(ev && m_beat == NB - 1));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (ev) chk({tag, ".data"}, out_data, beat_of(mq[0], m_beat));
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive(0, '0, 0, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    mq.delete(); m_beat = 0; m_ovf = 0;
  endtask

  initial begin
    nrst = 1'b0;
    drive(0, '0, 0, 0);

    // Table: single vector, fill/overflow, clear priority, full+pop, backpressure, count-1 write+pop.
    add(1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    add_beats(0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 1, 0, 1);
    add(1, 2, 0, 0, 1, 0, 0, 2, 0, 1);
    add(1, 3, 0, 0, 1, 0, 0, 2, 1, 1);
    add(1, 3, 0, 1, 1, 0, 0, 2, 1, 1);
    add(0, 0, 0, 1, 1, 0, 0, 2, 0, 1);
    add_beats(1, 2, 1);
    add(1, 4, 1, 0, 1, 0, 0, 2, 0, 2);
    add_beats(2, 2, 1);
    add(0, 0, 1, 0, 1, 0, 0, 1, 0, 4);
    add_beats(4, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 5, 1, 0, 1, 0, 0, 1, 0, 5);
    add(0, 0, 1, 0, 1, 1, 0, 1, 0, 5);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 1, 0, 1, 0, 5);
    add_beats(5, 1, 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 6, 1, 0, 1, 0, 0, 1, 0, 6);
    add_beats(6, 1, 1);
    add(1, 7, 1, 0, 1, 0, 0, 1, 0, 7);
    add_beats(7, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.last", 32'(out_last), 0);
    chk("rst.beat", 32'(out_beat_idx), 0);
    chk("rst.count", 32'(fifo_count), 0);
    chk("rst.ovf", 32'(overflow), 0);
    nrst = 1'b1;

    foreach (rows[i]) begin
      drive(rows[i].v, pat_vec(rows[i].pat), rows[i].rdy, rows[i].clr);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("row%0d.valid", i), 32'(out_valid), 32'(rows[i].e_valid));
      chk($sformatf("row%0d.beat", i), 32'(out_beat_idx), 32'(rows[i].e_beat));
      chk($sformatf("row%0d.last", i), 32'(out_last), 32'(rows[i].e_last));
      chk($sformatf("row%0d.count", i), 32'(fifo_count), 32'(rows[i].e_cnt));
      chk($sformatf("row%0d.ovf", i), 32'(overflow), 32'(rows[i].e_ovf));
      if (rows[i].e_valid)
        chk($sformatf("row%0d.data", i), out_data, beat_of(pat_vec(rows[i].e_pat), rows[i].e_beat));
    end
    drive(0, '0, 0, 0);

    // Asynchronous reset at beat 2, between clock edges.
    drive(1, pat_vec(9), 1, 0);
    @(posedge clk); @(negedge clk);
    drive(0, '0, 1, 0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    chk("arst.pre_beat", 32'(out_beat_idx), 2);
    out_ready = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("arst.valid", 32'(out_valid), 0);
    chk("arst.count", 32'(fifo_count), 0);
    chk("arst.beat", 32'(out_beat_idx), 0);
    chk("arst.last", 32'(out_last), 0);
    @(negedge clk);
    nrst = 1'b1;
    drive(1, pat_vec(10), 1, 0);
    @(posedge clk); @(negedge clk);
    drive(0, '0, 1, 0);
    chk("arst.next_valid", 32'(out_valid), 1);
    chk("arst.next_beat", 32'(out_beat_idx), 0);
    chk("arst.next_count", 32'(fifo_count), 1);
    chk("arst.next_data", out_data, beat_of(pat_vec(10), 0));

    // Randomized traffic against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic             v, r, cl;
      logic [OE*OB-1:0] d;
      check_model($sformatf("rnd%0d", c));
      v  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 9) < 7);
      cl = ($urandom_range(0, 19) == 0);
      d  = {$urandom, $urandom, $urandom, $urandom};
      drive(v, d, r, cl);
      @(posedge clk);
      model_edge(v, d, r, cl);
      @(negedge clk);
    end
    check_model("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
